i2c_bus_monitor: RTL

I2C_BUS_MONITOR -- requirements
Module: i2c_bus_monitor

---
 rtl/i2c_bus_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C START/STOP/byte decoder feeding an event FIFO.
// Define I2C_MON_GLITCH_FILTER_EN to add the FILTER_LEN-sample glitch filter on SDA/SCL.
module i2c_bus_monitor #(
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SDA,
    input  logic       SCL,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_type,
    output logic [7:0] evt_data,
    output logic       evt_ack,
    output logic       bus_busy,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;
    state_t r_state, w_next;
    logic [1:0] r_sda_s, r_scl_s;
    logic w_sda, w_scl, r_sda_p, r_scl_p;
    logic w_start, w_stop, w_rise, w_byte, w_push, w_pop, w_wr, w_empty, w_full;
    logic [2:0] r_cnt;
    logic [7:0] r_sh;
    logic r_busy, r_ovf;
    logic [10:0] w_din;
    logic [10:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sda_s <= 2'b11;
            r_scl_s <= 2'b11;
        end else begin
            r_sda_s <= {r_sda_s[0], SDA};
            r_scl_s <= {r_scl_s[0], SCL};
        end
    end

`ifdef I2C_MON_GLITCH_FILTER_EN
    logic r_sda_f, r_scl_f;
    logic [3:0] r_sda_c, r_scl_c;
    // A line only follows the synchroniser after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sda_f <= 1'b1;
            r_scl_f <= 1'b1;
            r_sda_c <= '0;
            r_scl_c <= '0;
        end else begin
            if (r_sda_s[1] == r_sda_f) r_sda_c <= '0;
            else if (r_sda_c == 4'(FILTER_LEN - 1)) begin
                r_sda_f <= r_sda_s[1];
                r_sda_c <= '0;
            end else r_sda_c <= r_sda_c + 4'd1;
            if (r_scl_s[1] == r_scl_f) r_scl_c <= '0;
            else if (r_scl_c == 4'(FILTER_LEN - 1)) begin
                r_scl_f <= r_scl_s[1];
                r_scl_c <= '0;
            end else r_scl_c <= r_scl_c + 4'd1;
        end
    end
    assign w_sda = r_sda_f;
    assign w_scl = r_scl_f;
`else
    logic w_unused_filter_len;
    assign w_unused_filter_len = ^FILTER_LEN;
    assign w_sda = r_sda_s[1];
    assign w_scl = r_scl_s[1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sda_p <= 1'b1;
            r_scl_p <= 1'b1;
        end else begin
            r_sda_p <= w_sda;
            r_scl_p <= w_scl;
        end
    end

    assign w_start = w_scl & r_scl_p & r_sda_p & ~w_sda;
    assign w_stop  = w_scl & r_scl_p & ~r_sda_p & w_sda;
    assign w_rise  = w_scl & ~r_scl_p;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = w_stop ? IDLE : w_start ? BITS : !w_rise ? r_state :
                 (r_state == BITS && r_cnt == 3'd7) ? ACK : (r_state == ACK) ? BITS : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_sh   <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_start | w_stop) r_cnt <= '0;
            else if (w_rise && r_state == BITS) begin
                r_cnt <= r_cnt + 3'd1;
                r_sh  <= {r_sh[6:0], w_sda};
            end
            if (w_start) r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
        end
    end

    assign w_byte = w_rise & (r_state == ACK);
    assign w_push = w_byte | w_start | w_stop;
    assign w_din  = w_stop ? {2'b11, 9'd0} : w_start ? {(r_busy ? 2'b10 : 2'b01), 9'd0}
                           : {2'b00, r_sh, ~w_sda};

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = ~w_empty & evt_ready;
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= w_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_push & ~w_wr) r_ovf <= 1'b1;
        end
    end

    assign evt_valid = ~w_empty;
    assign {evt_type, evt_data, evt_ack} = w_empty ? 11'd0 : r_mem[r_rp[AW-1:0]];
    assign bus_busy = r_busy;
    assign overflow = r_ovf;
endmodule
